// File: rtl/imm_ext_stage_if.sv
// Handshake bundle for imm_ext_stage: producer-side immediate stream in, extended stream out.
// The stage connects through the slave modport; the driving environment uses master.
interface imm_ext_stage_if #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 16,
  parameter int TAG_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [IN_W-1:0]   in_imm;
  logic [1:0]        in_mode;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_imm;
  logic [TAG_W-1:0]  out_tag;
  logic              out_ovf;
  logic [1:0]        occupancy;

  modport master (
    output in_valid, in_imm, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_tag, out_ovf, occupancy
  );

  modport slave (
    input  in_valid, in_imm, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_tag, out_ovf, occupancy
  );
endinterface

// File: rtl/imm_ext_stage.sv
// Registered immediate-extension stage (sign / zero / sign+shift / upper) with a 2-entry skid buffer.
// Define IMM_EXT_OVF_EN to store and report the mode-2 shift-overflow flag per entry.
module imm_ext_stage #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 16,
  parameter int SHIFT = 1,
  parameter int TAG_W = 4
) (
  input logic          clk,
  input logic          rst,
  imm_ext_stage_if.slave bus
);

  typedef struct packed {
    logic [OUT_W-1:0] imm;
    logic [TAG_W-1:0] tag;
`ifdef IMM_EXT_OVF_EN
    logic             ovf;
`endif
  } entry_t;

  entry_t           new_e;
  entry_t           head_q, head_d, skid_q, skid_d;
  logic             head_v_q, head_v_d, skid_v_q, skid_v_d;
  logic             in_ready_q, in_ready_d;
  logic             accept, drain;
  logic [OUT_W-1:0] sext;

`ifdef IMM_EXT_OVF_EN
  localparam int WIDE = OUT_W + SHIFT;
  logic [WIDE-1:0]  wide;
  logic [SHIFT:0]   wide_top;
`endif

  // Extension happens on the input side so the registered head is ready the cycle after accept.
  always_comb begin
    new_e     = '0;
    sext      = OUT_W'($signed(bus.in_imm));
`ifdef IMM_EXT_OVF_EN
    wide      = WIDE'($signed(bus.in_imm)) << SHIFT;
    wide_top  = wide[WIDE-1:OUT_W-1];
`endif
    unique case (bus.in_mode)
      2'd0: new_e.imm = sext;
      2'd1: new_e.imm = OUT_W'(bus.in_imm);
      2'd2: begin
`ifdef IMM_EXT_OVF_EN
        new_e.imm = wide[OUT_W-1:0];
        // The truncation is lossless only if every dropped bit matches the new sign bit.
        new_e.ovf = !((&wide_top) || !(|wide_top));
`else
        new_e.imm = sext << SHIFT;
`endif
      end
      default: new_e.imm = OUT_W'(bus.in_imm) << (OUT_W - IN_W);
    endcase
    new_e.tag = bus.in_tag;
  end

  assign accept = bus.in_valid && in_ready_q;
  assign drain  = head_v_q && bus.out_ready;

  // NOTE: every always_comb output gets its hold value first, so no path can infer a latch.
  always_comb begin
    head_d   = head_q;
    skid_d   = skid_q;
    head_v_d = head_v_q;
    skid_v_d = skid_v_q;
    if (drain) begin
      if (skid_v_q) begin
        head_d   = skid_q;
        skid_v_d = 1'b0;
      end else if (accept) begin
        head_d   = new_e;
      end else begin
        head_v_d = 1'b0;
      end
    end else if (accept) begin
      if (head_v_q) begin
        skid_d   = new_e;
        skid_v_d = 1'b1;
      end else begin
        head_d   = new_e;
        head_v_d = 1'b1;
      end
    end
    // Registered ready: a full skid is the only state that refuses new work.
    in_ready_d = !skid_v_d;
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  // Data registers are reset too, so out_imm/out_tag read zero straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= '0;
      skid_q     <= '0;
      head_v_q   <= 1'b0;
      skid_v_q   <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      head_q     <= head_d;
      skid_q     <= skid_d;
      head_v_q   <= head_v_d;
      skid_v_q   <= skid_v_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = head_v_q;
  assign bus.out_imm   = head_q.imm;
  assign bus.out_tag   = head_q.tag;
  assign bus.occupancy = {1'b0, head_v_q} + {1'b0, skid_v_q};
`ifdef IMM_EXT_OVF_EN
  assign bus.out_ovf   = head_q.ovf;
`else
  assign bus.out_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_imm_ext_stage.sv
// Randomised scoreboard bench for imm_ext_stage: driver pushes model results on accept,
// a forked monitor pops and compares on every drain.
module tb_imm_ext_stage;
  localparam int IN_W  = 4;
  localparam int OUT_W = 16;
  localparam int SHIFT = 1;
  localparam int TAG_W = 4;

  typedef struct {
    logic [OUT_W-1:0] imm;
    logic [TAG_W-1:0] tag;
    logic             ovf;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  bit   rnd_ready = 0;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  imm_ext_stage_if #(.IN_W(IN_W), .OUT_W(OUT_W), .TAG_W(TAG_W)) bus ();

  imm_ext_stage #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Reference: treat the immediate as an integer and apply each mode arithmetically.
  function automatic exp_t model(logic [IN_W-1:0] imm, logic [1:0] mode, logic [TAG_W-1:0] tag);
    exp_t   r;
    longint u, s, p, half;
    u    = longint'(imm);
    s    = (u >= (longint'(1) << (IN_W - 1))) ? u - (longint'(1) << IN_W) : u;
    half = longint'(1) << (OUT_W - 1);
    r.tag = tag;
    r.ovf = 1'b0;
    case (mode)
      2'd0: r.imm = OUT_W'(s);
      2'd1: r.imm = OUT_W'(u);
      2'd2: begin
        p     = s * (longint'(1) << SHIFT);
        r.imm = OUT_W'(p);
`ifdef IMM_EXT_OVF_EN
        r.ovf = (p < -half) || (p >= half);
`endif
      end
      default: r.imm = OUT_W'(u * (longint'(1) << (OUT_W - IN_W)));
    endcase
    return r;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: got tag %0h expected no output", bus.out_tag);
        end else begin
          mon_e = sb.pop_front();
          check("out_imm", 32'(bus.out_imm), 32'(mon_e.imm));
          check("out_tag", 32'(bus.out_tag), 32'(mon_e.tag));
          check("out_ovf", 32'(bus.out_ovf), 32'(mon_e.ovf));
        end
      end
    end
  endtask

  // Advance to just after the next rising edge; optionally wiggle out_ready.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) bus.out_ready = ($urandom_range(0, 2) != 0);
  endtask

  task automatic send(logic [IN_W-1:0] imm, logic [1:0] mode, logic [TAG_W-1:0] tag);
    bit ok = 0;
    int n  = 0;
    bus.in_valid = 1'b1;
    bus.in_imm   = imm;
    bus.in_mode  = mode;
    bus.in_tag   = tag;
    while (!ok && n < 200) begin
      @(negedge clk);
      if (bus.in_ready) begin
        sb.push_back(model(imm, mode, tag));
        ok = 1;
      end else n++;
      tick();
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got no accept expected accept within 200 cycles (tag %0h)", tag);
    end
    bus.in_valid = 1'b0;
    bus.in_imm   = IN_W'($urandom);
    bus.in_mode  = 2'($urandom);
    bus.in_tag   = TAG_W'($urandom);
  endtask

  initial begin
    fork
      monitor_loop();
      begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
      end
    join_none

    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_imm   = '0;
    bus.in_mode  = '0;
    bus.in_tag   = '0;
    bus.out_ready = 1'b0;
    #12;
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_imm",   32'(bus.out_imm), 0);
    check("rst_out_tag",   32'(bus.out_tag), 0);
    check("rst_out_ovf",   32'(bus.out_ovf), 0);
    check("rst_occupancy", 32'(bus.occupancy), 0);
    check("rst_in_ready",  32'(bus.in_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Directed modes with a free-running consumer; first one also checks 1-cycle latency.
    bus.out_ready = 1'b1;
    send(4'hA, 2'd0, 4'd3);
    check("lat_out_valid", 32'(bus.out_valid), 1);
    check("lat_out_imm",   32'(bus.out_imm), 32'h0000_FFFA);
    check("lat_out_tag",   32'(bus.out_tag), 3);
    send(4'hA, 2'd1, 4'd4);
    send(4'hA, 2'd3, 4'd5);
    send(4'h7, 2'd2, 4'd6);
    check("b2b_out_valid", 32'(bus.out_valid), 1);
    send(4'h8, 2'd2, 4'd7);
    check("b2b_mode2_imm", 32'(bus.out_imm), 32'h0000_FFF0);
    repeat (3) tick();
    check("idle_occupancy", 32'(bus.occupancy), 0);

    // Backpressure: tags 1 and 2 fill head+skid, tag 3 must wait.
    bus.out_ready = 1'b0;
    send(4'h1, 2'd0, 4'd1);
    check("bp_ready_after1", 32'(bus.in_ready), 1);
    send(4'h2, 2'd1, 4'd2);
    check("bp_in_ready",  32'(bus.in_ready), 0);
    check("bp_occupancy", 32'(bus.occupancy), 2);
    bus.in_valid = 1'b1;
    bus.in_imm   = 4'h3;
    bus.in_mode  = 2'd3;
    bus.in_tag   = 4'd3;
    repeat (3) tick();
    check("bp_hold_ready", 32'(bus.in_ready), 0);
    check("bp_hold_tag",   32'(bus.out_tag), 1);
    check("bp_hold_occ",   32'(bus.occupancy), 2);
    bus.out_ready = 1'b1;
    send(4'h3, 2'd3, 4'd3);
    repeat (4) tick();
    check("bp_drained", sb.size(), 0);

    // Asynchronous reset while full.
    bus.out_ready = 1'b0;
    send(4'h4, 2'd0, 4'd8);
    send(4'h5, 2'd0, 4'd9);
    check("pre_rst_occ", 32'(bus.occupancy), 2);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 0);
    check("arst_occupancy", 32'(bus.occupancy), 0);
    check("arst_in_ready",  32'(bus.in_ready), 1);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    tick();
    bus.out_ready = 1'b1;
    send(4'hC, 2'd2, 4'd10);
    check("post_rst_valid", 32'(bus.out_valid), 1);

    // Randomised traffic with a stalling consumer.
    rnd_ready = 1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) tick();
      send(IN_W'($urandom), 2'($urandom), TAG_W'($urandom));
    end
    rnd_ready = 0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    tick();
    check("final_sb_empty",  sb.size(), 0);
    check("final_occupancy", 32'(bus.occupancy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
